// File: rtl/spike_encoder.sv
// Rate encoder: converts a frame of per-channel intensities into T_STEPS timesteps
// of spikes by accumulating each intensity and emitting the accumulator carry.
module spike_encoder #(
  parameter int unsigned N_IN    = 8,
  parameter int unsigned VAL_W   = 8,
  parameter int unsigned T_STEPS = 16
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N_IN*VAL_W-1:0]   in_data,
  output logic [N_IN-1:0]         spike_out,
  output logic                    spike_valid,
  output logic                    frame_first,
  output logic                    frame_last
);

  localparam int unsigned STEP_W = (T_STEPS > 1) ? $clog2(T_STEPS) : 1;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(T_STEPS - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                  r_state;
  logic [N_IN*VAL_W-1:0]   r_val;
  logic [N_IN*VAL_W-1:0]   r_acc;
  logic [STEP_W-1:0]       r_step;
  logic [N_IN-1:0]         w_carry;
  logic [N_IN*VAL_W-1:0]   w_acc_nxt;

  // Per-channel accumulate; the carry out is the spike, the low bits wrap.
  for (genvar gi = 0; gi < int'(N_IN); gi++) begin : g_ch
    logic [VAL_W:0] w_sum;
    assign w_sum = {1'b0, r_acc[gi*VAL_W +: VAL_W]} + {1'b0, r_val[gi*VAL_W +: VAL_W]};
    assign w_carry[gi] = w_sum[VAL_W];
    assign w_acc_nxt[gi*VAL_W +: VAL_W] = w_sum[VAL_W-1:0];
  end

  // in_ready is kept as a flop that mirrors (r_state == IDLE).
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state     <= IDLE;
      r_val       <= '0;
      r_acc       <= '0;
      r_step      <= '0;
      in_ready    <= 1'b1;
      spike_out   <= '0;
      spike_valid <= 1'b0;
      frame_first <= 1'b0;
      frame_last  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          spike_out   <= '0;
          spike_valid <= 1'b0;
          frame_first <= 1'b0;
          frame_last  <= 1'b0;
          if (in_valid && in_ready) begin
            r_val    <= in_data;
            r_acc    <= '0;
            r_step   <= '0;
            in_ready <= 1'b0;
            r_state  <= RUN;
          end
        end
        RUN: begin
          spike_out   <= w_carry;
          r_acc       <= w_acc_nxt;
          spike_valid <= 1'b1;
          frame_first <= (r_step == '0);
          frame_last  <= (r_step == LAST_STEP);
          r_step      <= r_step + STEP_W'(1);
          if (r_step == LAST_STEP) begin
            in_ready <= 1'b1;
            r_state  <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spike_encoder.sv
// Directed self-checking bench for spike_encoder (N_IN=8, VAL_W=8, T_STEPS=16).
module tb_spike_encoder;

  localparam int unsigned N_IN    = 8;
  localparam int unsigned VAL_W   = 8;
  localparam int unsigned T_STEPS = 16;

  logic                  clk;
  logic                  rstn;
  logic                  in_valid;
  logic                  in_ready;
  logic [N_IN*VAL_W-1:0] in_data;
  logic [N_IN-1:0]       spike_out;
  logic                  spike_valid;
  logic                  frame_first;
  logic                  frame_last;

  int checks   = 0;
  int failures = 0;

  // Channel i = byte i: {0,16,64,128,192,255,1,240}
  localparam logic [63:0] BASE_DATA = {8'd240, 8'd1, 8'd255, 8'd192, 8'd128, 8'd64, 8'd16, 8'd0};
  int exp_cnt [8] = '{0, 1, 4, 8, 12, 15, 0, 15};

  logic [N_IN-1:0] cap_so [16];
  logic [15:0]     cap_sv, cap_ff, cap_fl, cap_rdy;

  spike_encoder #(.N_IN(N_IN), .VAL_W(VAL_W), .T_STEPS(T_STEPS)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .spike_out   (spike_out),
    .spike_valid (spike_valid),
    .frame_first (frame_first),
    .frame_last  (frame_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one frame and record the 16 following output cycles.
  task automatic capture_frame(input logic [63:0] data, input bit disturb);
    in_data  = data;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (disturb) begin
        in_valid = 1'($urandom);
        in_data  = {$urandom, $urandom};
      end
      cap_rdy[k] = in_ready;
      tick();
      cap_so[k] = spike_out;
      cap_sv[k] = spike_valid;
      cap_ff[k] = frame_first;
      cap_fl[k] = frame_last;
    end
    in_valid = 1'b0;
  endtask

  function automatic int count_ch(input int ch);
    int n = 0;
    for (int k = 0; k < 16; k++) n += int'(cap_so[k][ch]);
    return n;
  endfunction

  function automatic logic [15:0] pattern_ch(input int ch);
    logic [15:0] p;
    for (int k = 0; k < 16; k++) p[k] = cap_so[k][ch];
    return p;
  endfunction

  task automatic test_reset();
    rstn = 1'b0; in_valid = 1'b0; in_data = '0;
    tick(); tick();
    checks++;
    if ({spike_out, spike_valid, frame_first, frame_last} !== 11'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_state: out=%h sv=%b ff=%b fl=%b rdy=%b, want 0/0/0/0/1",
               spike_out, spike_valid, frame_first, frame_last, in_ready);
    end
    rstn = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      checks++;
      if (in_ready !== 1'b1 || spike_valid !== 1'b0 || spike_out !== '0) begin
        failures++;
        $display("FAIL idle_hold c=%0d: rdy=%b sv=%b out=%h, want 1/0/00", c, in_ready, spike_valid, spike_out);
      end
    end
  endtask

  task automatic test_frame();
    capture_frame(BASE_DATA, 1'b0);
    for (int ch = 0; ch < 8; ch++) begin
      checks++;
      if (count_ch(ch) !== exp_cnt[ch]) begin
        failures++;
        $display("FAIL frame_count ch=%0d: got %0d want %0d", ch, count_ch(ch), exp_cnt[ch]);
      end
    end
    checks++;
    if (cap_sv !== 16'hFFFF) begin
      failures++; $display("FAIL frame_valid: got %h want ffff", cap_sv);
    end
    checks++;
    if (cap_ff !== 16'h0001) begin
      failures++; $display("FAIL frame_first: got %h want 0001", cap_ff);
    end
    checks++;
    if (cap_fl !== 16'h8000) begin
      failures++; $display("FAIL frame_last: got %h want 8000", cap_fl);
    end
    tick();
    checks++;
    if (spike_valid !== 1'b0 || in_ready !== 1'b1 || spike_out !== '0) begin
      failures++;
      $display("FAIL frame_end: sv=%b rdy=%b out=%h, want 0/1/00", spike_valid, in_ready, spike_out);
    end
  endtask

  task automatic test_patterns();
    checks++;
    if (pattern_ch(3) !== 16'hAAAA) begin
      failures++; $display("FAIL pattern_128: got %h want aaaa", pattern_ch(3));
    end
    checks++;
    if (pattern_ch(5) !== 16'hFFFE) begin
      failures++; $display("FAIL pattern_255: got %h want fffe", pattern_ch(5));
    end
    checks++;
    if (pattern_ch(0) !== 16'h0000) begin
      failures++; $display("FAIL pattern_0: got %h want 0000", pattern_ch(0));
    end
  endtask

  task automatic test_disturb();
    capture_frame(BASE_DATA, 1'b1);
    for (int ch = 0; ch < 8; ch++) begin
      checks++;
      if (count_ch(ch) !== exp_cnt[ch]) begin
        failures++;
        $display("FAIL disturb_count ch=%0d: got %0d want %0d", ch, count_ch(ch), exp_cnt[ch]);
      end
    end
    checks++;
    if (pattern_ch(3) !== 16'hAAAA || pattern_ch(5) !== 16'hFFFE) begin
      failures++;
      $display("FAIL disturb_pattern: ch3=%h ch5=%h want aaaa fffe", pattern_ch(3), pattern_ch(5));
    end
    checks++;
    if (cap_rdy !== 16'h0000 || cap_sv !== 16'hFFFF) begin
      failures++;
      $display("FAIL disturb_ready: rdy=%h sv=%h want 0000 ffff", cap_rdy, cap_sv);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [33:0] sv_seq;
    int          cnt_a7;
    int          cnt_b [8];
    cnt_a7 = 0;
    for (int ch = 0; ch < 8; ch++) cnt_b[ch] = 0;
    in_data  = BASE_DATA;
    in_valid = 1'b1;
    tick();
    in_data = {8{8'd32}};
    for (int c = 0; c < 34; c++) begin
      tick();
      sv_seq[c] = spike_valid;
      if (c < 16) cnt_a7 += int'(spike_out[7]);
      if (c >= 17 && c <= 32)
        for (int ch = 0; ch < 8; ch++) cnt_b[ch] += int'(spike_out[ch]);
      if (c == 16) in_valid = 1'b0;
    end
    checks++;
    if (sv_seq !== {1'b0, 16'hFFFF, 1'b0, 16'hFFFF}) begin
      failures++;
      $display("FAIL b2b_valid_seq: got %h want %h", sv_seq, {1'b0, 16'hFFFF, 1'b0, 16'hFFFF});
    end
    checks++;
    if (cnt_a7 !== 15) begin
      failures++; $display("FAIL b2b_first_ch7: got %0d want 15", cnt_a7);
    end
    for (int ch = 0; ch < 8; ch++) begin
      checks++;
      if (cnt_b[ch] !== 2) begin
        failures++; $display("FAIL b2b_second ch=%0d: got %0d want 2", ch, cnt_b[ch]);
      end
    end
  endtask

  task automatic test_reset_mid();
    in_data  = BASE_DATA;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    rstn = 1'b0;
    tick();
    checks++;
    if ({spike_out, spike_valid, frame_first, frame_last} !== 11'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL midreset_state: out=%h sv=%b ff=%b fl=%b rdy=%b, want 0/0/0/0/1",
               spike_out, spike_valid, frame_first, frame_last, in_ready);
    end
    rstn = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if (spike_valid !== 1'b0 || in_ready !== 1'b1) begin
        failures++; $display("FAIL midreset_quiet c=%0d: sv=%b rdy=%b want 0/1", c, spike_valid, in_ready);
      end
    end
    capture_frame(BASE_DATA, 1'b0);
    for (int ch = 0; ch < 8; ch++) begin
      checks++;
      if (count_ch(ch) !== exp_cnt[ch]) begin
        failures++;
        $display("FAIL midreset_count ch=%0d: got %0d want %0d", ch, count_ch(ch), exp_cnt[ch]);
      end
    end
    checks++;
    if (cap_sv !== 16'hFFFF || pattern_ch(3) !== 16'hAAAA) begin
      failures++;
      $display("FAIL midreset_frame: sv=%h ch3=%h want ffff aaaa", cap_sv, pattern_ch(3));
    end
    tick();
  endtask

  initial begin
    rstn     = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    test_reset();
    test_frame();
    test_patterns();
    test_disturb();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spike_encoder.md
SPIKE_ENCODER -- requirements
Module: spike_encoder

Interface
REQ-001 Parameter N_IN, default 8: number of input channels, which equals the spike vector width of the downstream lif stage.
REQ-002 Parameter VAL_W, default 8: intensity width per channel; legal range 2..16.
REQ-003 Parameter T_STEPS, default 16: timesteps per frame; legal range 2..1024.
REQ-004 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 Port rstn, input, 1 bit: reset, synchronous, active-low.
REQ-006 Port in_valid, input, 1 bit: in_data holds a frame to encode.
REQ-007 Port in_ready, output, 1 bit: encoder can accept a frame.
REQ-008 Port in_data, input, N_IN*VAL_W bits: unsigned intensities; channel i occupies bits [i*VAL_W +: VAL_W].
REQ-009 Port spike_out, output, N_IN bits: one spike bit per channel for the current timestep; feeds the lif spike input.
REQ-010 Port spike_valid, output, 1 bit: spike_out is a live timestep.
REQ-011 Port frame_first, output, 1 bit: current timestep is step 0 of a frame.
REQ-012 Port frame_last, output, 1 bit: current timestep is step T_STEPS-1 of a frame.

Function
REQ-013 The block SHALL have two states: IDLE and RUN.
REQ-014 in_ready SHALL be 1 exactly when the state is IDLE.
REQ-015 A frame is accepted at a rising edge with in_valid=1 and in_ready=1.
- On acceptance: latch all N_IN intensities, clear every channel accumulator (VAL_W bits) to 0, clear the step counter to 0, go to RUN.
REQ-016 While in RUN, on each rising edge, for every channel i:
- sum_i = acc_i + intensity_i, computed VAL_W+1 bits wide.
- spike_out[i] <= sum_i[VAL_W] (the carry bit).
- acc_i <= sum_i[VAL_W-1:0].
REQ-017 Also on each RUN edge:
- spike_valid <= 1.
- frame_first <= (step==0).
- frame_last <= (step==T_STEPS-1).
- step increments.
- At step==T_STEPS-1, next state is IDLE.
REQ-018 Total spikes on channel i over one frame SHALL equal floor(intensity_i*T_STEPS / 2^VAL_W).
REQ-019 Latency: the first timestep appears in the cycle after the acceptance edge plus one RUN edge. spike_valid then stays high for exactly T_STEPS consecutive cycles.
REQ-020 In IDLE, each edge SHALL drive spike_out, spike_valid, frame_first and frame_last to 0.
REQ-021 in_valid and in_data changes during RUN SHALL have no effect; no frame is queued.
REQ-022 Back-to-back frames: acceptance is possible at the edge following the frame_last edge. This gives exactly one cycle with spike_valid=0 between frames.
REQ-023 Intensity 0 SHALL produce no spikes.
REQ-024 Intensity 2^VAL_W-1 SHALL spike on every step except step 0.
REQ-025 The accumulator SHALL wrap modulo 2^VAL_W and never saturate.

Reset
REQ-026 When rstn=0 at a rising edge, the block SHALL go to IDLE and set to 0: spike_out, spike_valid, frame_first, frame_last, all accumulators, all latched intensities and the step counter.
REQ-027 Reset SHALL take priority over acceptance and over RUN updates.
REQ-028 A frame interrupted by reset SHALL be discarded with no further spike_valid.
REQ-029 in_ready SHALL read 1 in the cycle after reset is released.

Verification (N_IN=8, VAL_W=8, T_STEPS=16)
REQ-030 Reset, then hold in_valid=0 for 20 cycles -> in_ready=1, spike_valid=0, spike_out=0 throughout.
REQ-031 Frame with intensities {0,16,64,128,192,255,1,240} -> per-channel spike counts {0,1,4,8,12,15,0,15}; spike_valid high for 16 cycles; frame_first on cycle 1 only; frame_last on cycle 16 only.
REQ-032 Channel at 128 -> spikes on steps 1,3,5,...,15 only. Channel at 255 -> spikes on steps 1..15, none on step 0.
REQ-033 Toggle in_valid and in_data during RUN -> output identical to an undisturbed run; in_ready=0 throughout RUN.
REQ-034 in_valid held high with two frames -> second acceptance one cycle after frame_last; exactly one idle cycle between the 16-step bursts.
REQ-035 rstn=0 at step 7 -> next cycle: all outputs 0, in_ready=1. A new frame accepted afterwards encodes from acc=0 with the exact counts of REQ-018.
